// File: rtl/tone_sched_pkg.sv
// tone_sched_pkg: shared note codes, source indices, FSM states and jingle lengths for tone_sched.
package tone_sched_pkg;
  localparam logic [2:0] NOTE_SIL = 3'd0;
  localparam logic [2:0] NOTE_C5  = 3'd1;
  localparam logic [2:0] NOTE_E5  = 3'd2;
  localparam logic [2:0] NOTE_G5  = 3'd3;
  localparam logic [2:0] NOTE_A5  = 3'd4;
  localparam logic [2:0] NOTE_C6  = 3'd5;
  localparam logic [2:0] NOTE_E6  = 3'd6;
  localparam logic [2:0] NOTE_G6  = 3'd7;
  // source index doubles as the grant/done bit position
  localparam logic [1:0] SRC_CNT  = 2'd0;
  localparam logic [1:0] SRC_GOAL = 2'd1;
  localparam logic [1:0] SRC_WIN  = 2'd2;
  localparam logic [1:0] SRC_LOSE = 2'd3;
  localparam logic [2:0] LEN_CNT  = 3'd1;
  localparam logic [2:0] LEN_GOAL = 3'd3;
  localparam logic [2:0] LEN_WIN  = 3'd4;
  localparam logic [2:0] LEN_LOSE = 3'd3;
  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GAP} state_e;
  function automatic logic [2:0] jingle_len(input logic [1:0] src);
    return src == SRC_CNT ? LEN_CNT : src == SRC_GOAL ? LEN_GOAL : src == SRC_WIN ? LEN_WIN : LEN_LOSE;
  endfunction
endpackage

// File: rtl/tone_sched_jingle_rom.sv
// tone_jingle_rom: combinational jingle table, (source, note index) -> note code, duration in ticks, last-note flag.
module tone_jingle_rom
  import tone_sched_pkg::*;
(
  input  logic [1:0] src_i,
  input  logic [1:0] idx_i,
  output logic [2:0] note_o,
  output logic [8:0] dur_o,
  output logic       last_o
);
  always_comb begin
    note_o = NOTE_SIL;
    dur_o  = 9'd0;
    case ({src_i, idx_i})
      {SRC_CNT,  2'd0}: begin note_o = NOTE_A5; dur_o = 9'd150; end
      {SRC_GOAL, 2'd0}: begin note_o = NOTE_C6; dur_o = 9'd80;  end
      {SRC_GOAL, 2'd1}: begin note_o = NOTE_E6; dur_o = 9'd80;  end
      {SRC_GOAL, 2'd2}: begin note_o = NOTE_G6; dur_o = 9'd120; end
      {SRC_WIN,  2'd0}: begin note_o = NOTE_C5; dur_o = 9'd150; end
      {SRC_WIN,  2'd1}: begin note_o = NOTE_E5; dur_o = 9'd150; end
      {SRC_WIN,  2'd2}: begin note_o = NOTE_G5; dur_o = 9'd150; end
      {SRC_WIN,  2'd3}: begin note_o = NOTE_C6; dur_o = 9'd300; end
      {SRC_LOSE, 2'd0}: begin note_o = NOTE_G5; dur_o = 9'd200; end
      {SRC_LOSE, 2'd1}: begin note_o = NOTE_E5; dur_o = 9'd200; end
      {SRC_LOSE, 2'd2}: begin note_o = NOTE_C5; dur_o = 9'd400; end
      default: begin note_o = NOTE_SIL; dur_o = 9'd0; end
    endcase
  end
  assign last_o = {1'b0, idx_i} == jingle_len(src_i) - 3'd1;
endmodule

// File: rtl/tone_sched.sv
// tone_sched: priority sequencer for the shared tone output, stepping through jingle notes and gaps.
// Define TONE_SCHED_QUEUE_EN to hold cnt/goal requests that arrive while busy.
module tone_sched
  import tone_sched_pkg::*;
#(
  parameter int TICK_DIV  = 100000,
  parameter int GAP_TICKS = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_cnt,
  input  logic       req_goal,
  input  logic       req_win,
  input  logic       req_lose,
  output logic [2:0] note_code,
  output logic       tone_en,
  output logic       busy,
  output logic [3:0] grant,
  output logic [3:0] done
);
  state_e      state_q, state_d;
  logic [3:0]  pend_q, pend_d;
  logic [1:0]  src_q, src_d, idx_q, idx_d;
  logic [16:0] tick_q, tick_d;
  logic [8:0]  dur_q, dur_d;
  logic [2:0]  rom_note, len;
  logic [8:0]  rom_dur;
  logic        rom_last, tick_end, play_end, gap_end, preempt, restart;
  logic [3:0]  req, acc, clr;
  logic [1:0]  pick;

  tone_jingle_rom u_rom (
    .src_i (src_q),
    .idx_i (idx_q),
    .note_o(rom_note),
    .dur_o (rom_dur),
    .last_o(rom_last)
  );

  assign req = {req_lose, req_win, req_goal, req_cnt};
`ifdef TONE_SCHED_QUEUE_EN
  assign acc = 4'hf;
`else
  assign acc = state_q == S_IDLE ? 4'hf : 4'hc;
`endif
  assign len      = jingle_len(src_q);
  assign tick_end = tick_q == 17'(TICK_DIV - 1);
  assign play_end = tick_end && dur_q == rom_dur - 9'd1;
  assign gap_end  = tick_end && dur_q == 9'(GAP_TICKS - 1);
  // an index already past the last note marks a jingle that was cut short
  assign preempt  = state_q != S_IDLE && !src_q[1] && (pend_q[SRC_WIN] || pend_q[SRC_LOSE]) && {1'b0, idx_q} < len;
  assign pick     = pend_q[SRC_WIN] ? SRC_WIN : pend_q[SRC_LOSE] ? SRC_LOSE : pend_q[SRC_GOAL] ? SRC_GOAL : SRC_CNT;

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    idx_d   = idx_q;
    clr     = 4'h0;
    done    = 4'h0;
    restart = 1'b0;
    if (state_q == S_IDLE) begin
      if (|pend_q) begin
        state_d = S_PLAY;
        src_d   = pick;
        idx_d   = 2'd0;
        clr     = 4'b0001 << pick;
        restart = 1'b1;
      end
    end else if (preempt) begin
      state_d = S_GAP;
      idx_d   = len[1:0];
      restart = 1'b1;
    end else if (state_q == S_PLAY) begin
      state_d = play_end ? S_GAP : S_PLAY;
      restart = play_end;
    end else if (gap_end) begin
      restart = 1'b1;
      if (!rom_last && {1'b0, idx_q} < len) begin
        state_d = S_PLAY;
        idx_d   = idx_q + 2'd1;
      end else begin
        state_d = S_IDLE;
        done    = rom_last ? 4'b0001 << src_q : 4'h0;
      end
    end
    tick_d = restart || tick_end ? 17'd0 : tick_q + 17'd1;
    dur_d  = restart ? 9'd0 : tick_end ? dur_q + 9'd1 : dur_q;
    pend_d = (pend_q & ~clr) | (req & acc);
    if (req[SRC_WIN]) pend_d[SRC_LOSE] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pend_q  <= 4'h0;
      src_q   <= 2'd0;
      idx_q   <= 2'd0;
      tick_q  <= 17'd0;
      dur_q   <= 9'd0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      src_q   <= src_d;
      idx_q   <= idx_d;
      tick_q  <= tick_d;
      dur_q   <= dur_d;
    end
  end

  assign note_code = state_q == S_PLAY ? rom_note : NOTE_SIL;
  assign tone_en   = state_q == S_PLAY;
  assign busy      = state_q != S_IDLE;
  assign grant     = busy ? 4'b0001 << src_q : 4'h0;
endmodule

// File: tb/tb_tone_sched.sv
// tb_tone_sched: scoreboard bench for tone_sched; expected output segments and done pulses are queued at stimulus time.
module tb_tone_sched;
  logic clk = 1'b0, rst_n = 1'b0;
  logic req_cnt = 1'b0, req_goal = 1'b0, req_win = 1'b0, req_lose = 1'b0;
  logic [2:0] note_code;
  logic tone_en, busy;
  logic [3:0] grant, done;
  int n_chk = 0, n_fail = 0, cyc = 0;

  typedef struct {logic [8:0] key; int len; int start;} seg_t;
  seg_t exp_q[$];
  logic [3:0] done_q[$];
  logic [8:0] cur_key = 9'd0;
  int cur_len = 0, cur_start = 0;
  logic after_done = 1'b0;

  int jn[4][4] = '{'{4, 0, 0, 0}, '{5, 6, 7, 0}, '{1, 2, 3, 5}, '{3, 2, 1, 0}};
  int jd[4][4] = '{'{150, 0, 0, 0}, '{80, 80, 120, 0}, '{150, 150, 150, 300}, '{200, 200, 400, 0}};
  int jl[4] = '{1, 3, 4, 3};

  tone_sched #(.TICK_DIV(4), .GAP_TICKS(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_cnt(req_cnt), .req_goal(req_goal), .req_win(req_win), .req_lose(req_lose),
    .note_code(note_code), .tone_en(tone_en), .busy(busy), .grant(grant), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] seg_key(input int s, input int note);
    return {1'b1, 4'(1 << s), 1'(note != 0), 3'(note)};
  endfunction

  task automatic push_seg(input int s, input int note, input int len, input int start);
    seg_t e;
    e.key = seg_key(s, note);
    e.len = len;
    e.start = start;
    exp_q.push_back(e);
  endtask

  task automatic push_j(input int s, input int start);
    for (int i = 0; i < jl[s]; i++) begin
      push_seg(s, jn[s][i], jd[s][i] * 4, i == 0 ? start : -1);
      push_seg(s, 0, 8, -1);
    end
    done_q.push_back(4'(1 << s));
  endtask

  task automatic pulse(input logic [3:0] r, output int p);
    @(posedge clk); #1;
    {req_lose, req_win, req_goal, req_cnt} = r;
    p = cyc;
    @(posedge clk); #1;
    {req_lose, req_win, req_goal, req_cnt} = 4'h0;
  endtask

  task automatic wait_note(input logic [2:0] n);
    int k = 0;
    do begin @(negedge clk); k++; end while (note_code !== n && k < 5000);
    if (note_code !== n) check("wait_note", note_code, n);
  endtask

  task automatic drain();
    int k = 0;
    while ((exp_q.size() != 0 || done_q.size() != 0 || busy) && k < 20000) begin
      @(negedge clk);
      k++;
    end
    check("drain_in_time", k < 20000, 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_note"}, note_code, 0);
    check({tag, "_tone_en"}, tone_en, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_grant"}, grant, 0);
    check({tag, "_done"}, done, 0);
  endtask

  always @(negedge clk) begin
    logic [8:0] key_now;
    seg_t e;
    key_now = {busy, grant, tone_en, note_code};
    if (after_done) check("busy_after_done", busy, 0);
    after_done = done != 4'h0;
    if (done != 4'h0) begin
      if (done_q.size() == 0) check("done_extra", done, 0);
      else check("done", done, done_q.pop_front());
    end
    if (key_now !== cur_key) begin
      if (cur_key != 9'd0) begin
        if (exp_q.size() == 0) check("seg_extra", cur_key, 0);
        else begin
          e = exp_q.pop_front();
          check("seg_key", cur_key, e.key);
          if (e.len >= 0) check("seg_len", cur_len, e.len);
          if (e.start >= 0) check("seg_start", cur_start, e.start);
        end
      end
      cur_key = key_now;
      cur_len = 1;
      cur_start = cyc;
    end else cur_len++;
  end

  initial begin
    int p, s;
    repeat (3) @(posedge clk); #1;
    check_quiet("reset");
    #2 rst_n = 1'b1;
    repeat (6) @(posedge clk);
    pulse(4'b0001, p);
    push_j(0, p + 2);
    drain();
    pulse(4'b0010, p);
    push_j(1, p + 2);
    drain();
    pulse(4'b0011, p);
    push_j(1, p + 2);
    push_j(0, p + 1147);
    drain();
    pulse(4'b0010, p);
    push_seg(1, 5, 320, p + 2);
    push_seg(1, 0, 8, -1);
    wait_note(3'd6);
    s = cyc;
    repeat (38) @(posedge clk);
    #1 req_win = 1'b1;
    p = cyc;
    @(posedge clk); #1 req_win = 1'b0;
    push_seg(1, 6, 40, s);
    push_seg(1, 0, 8, -1);
    push_j(2, p + 11);
    drain();
    pulse(4'b1100, p);
    push_j(2, p + 2);
    wait_note(3'd2);
    pulse(4'b0010, s);
`ifdef TONE_SCHED_QUEUE_EN
    push_j(1, p + 3035);
`endif
    drain();
    pulse(4'b0100, p);
    push_seg(2, 1, 600, p + 2);
    push_seg(2, 0, 8, -1);
    wait_note(3'd2);
    s = cyc;
    push_seg(2, 2, 100, s);
    repeat (100) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_quiet("async_rst");
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    drain();
    pulse(4'b0001, p);
    push_j(0, p + 2);
    drain();
    check("exp_q_left", exp_q.size(), 0);
    check("done_q_left", done_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/tone_sched.md
Name: tone_sched

Overview:
- Sequencer/arbiter for the single shared tone output (pmod audio path).
- Accepts one-cycle sound requests from the game FSM: countdown beep, goal, win jingle, lose jingle.
- Picks one request by priority and steps through its note list from a fixed jingle table.
- Drives a note code and enable to the downstream tone generator; reports busy, grant and completion.

Parameters:
TICK_DIV, 100000, clk cycles per duration tick (1 ms at 100 MHz); must be >= 2
GAP_TICKS, 20, silent ticks after every note, including the last

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
req_cnt  in  1  countdown beep request pulse
req_goal  in  1  goal sound request pulse
req_win  in  1  win jingle request pulse
req_lose  in  1  lose jingle request pulse
note_code  out  3  0 = silence, 1..7 = C5,E5,G5,A5,C6,E6,G6
tone_en  out  1  high while a note is sounding
busy  out  1  high in any state other than IDLE
grant  out  4  one-hot active source {lose,win,goal,cnt}; 0 in IDLE
done  out  4  one-cycle pulse, bit of the source that finished normally

Behaviour:
- Reset: all outputs 0, all pending flags 0, FSM in IDLE, tick and duration counters 0.
- Reset asserted mid-jingle aborts immediately with no done pulse.
- Pending flags:
  - A request pulse sets that source's pending flag on the next edge.
  - The flag clears when the source is granted, or when the source is preempted or dropped.
- Priority: win > lose > goal > cnt.
  - req_win and req_lose in the same cycle: win is taken and lose pending is cleared.
- States: IDLE, PLAY, GAP.
  - IDLE: if any flag is pending, load the highest-priority source, note index 0, and go to PLAY.
  - Request at edge t: pending at t+1, PLAY with valid note_code and grant at t+2.
  - PLAY: note_code = table entry, tone_en = 1. After the entry's duration in ticks, go to GAP.
  - GAP: note_code = 0, tone_en = 0 for GAP_TICKS. Then:
    - if more notes remain, go to PLAY at index+1;
    - otherwise pulse done[src] and go to IDLE. A pending request is granted on the cycle after IDLE entry.
- Timing:
  - The tick prescaler and the duration counter restart on every PLAY/GAP entry.
  - A state lasting N ticks lasts exactly N*TICK_DIV cycles.
- Preemption:
  - A win/lose pending while a goal/cnt jingle is in PLAY or GAP forces an immediate move to GAP with index set past the last note.
  - The preempted source gets no done pulse.
  - After the gap, the win/lose jingle starts.
  - win/lose jingles are never preempted.
- Jingle table (note:ticks):
  - cnt = A5:150
  - goal = C6:80, E6:80, G6:120
  - win = C5:150, E5:150, G5:150, C6:300
  - lose = G5:200, E5:200, C5:400
- Widths:
  - Duration counter is 9 bits and the tick counter is 17 bits.
  - Index counter is 2 bits and does not wrap: the length compare precedes the increment.

Optional Feature:
- Macro: TONE_SCHED_QUEUE_EN.
- Defined:
  - A request arriving while busy (including from the active source) is held in its pending flag and served after the current jingle.
  - One request is held per source; repeat pulses merge into it.
- Undefined:
  - While busy, req_cnt and req_goal pulses are discarded. Their pending flags are only set in IDLE.
  - win/lose requests are still accepted and still preempt.
- Port list is the same in both builds.

Decomposition:
- Package tone_sched_pkg holds:
  - note code constants
  - source index constants and grant bit positions
  - FSM state encoding
  - per-source jingle lengths
- One sub-module: tone_jingle_rom. It is combinational: (src, index) -> (note_code, duration_ticks, last flag).
- The prescaler stays inline.

Test Plan:
Bench setting for all scenarios: TICK_DIV = 4, GAP_TICKS = 2.
1. req_cnt pulse at cycle 10 -> grant = 0001 and note_code = 4 from cycle 12 for 600 cycles; silent for 8 cycles; done[0] pulses once; busy falls the following cycle.
2. req_goal -> note_code sequence 5, 0, 6, 0, 7, 0 with PLAY lengths 320/320/480 cycles and 8-cycle gaps; single done[1].
3. req_cnt and req_goal in the same cycle -> goal plays first. Then cnt plays after one IDLE cycle with the queue enabled; with the queue disabled cnt also plays, since it was pending in IDLE.
4. req_win during note 2 of goal -> goal aborts into GAP, no done[1]; the win sequence 1, 2, 3, 5 follows; done[2] pulses.
5. req_win and req_lose in the same cycle -> only the win jingle plays; lose is never granted; done = 0100 only.
6. rst_n low for 3 cycles in the middle of the win jingle -> outputs 0 asynchronously; no done pulse; a fresh req_cnt afterwards behaves as in scenario 1.
